// File: rtl/signed_seq_divider.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, sign fix-up, registered results.
// Optional macro DIV_ZERO_CHECK_EN short-circuits a zero divisor to an error result.
`timescale 1ns/1ps
module signed_seq_divider #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2*DATA_WIDTH-1:0]   dividend,
    input  logic [DATA_WIDTH-1:0]     divisor,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   quotient,
    output logic [DATA_WIDTH-1:0]     remainder,
    output logic                      div_by_zero
);
    localparam int QW = 2 * DATA_WIDTH;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;
    state_t state, state_next;

    logic [QW-1:0]         q_reg;
    logic [DATA_WIDTH:0]   rem_reg;
    logic [DATA_WIDTH-1:0] dvs_mag;
    logic                  dvd_neg, dvs_neg;
    logic [CW-1:0]         iter_cnt;
    logic                  last_iter, zero_div, sub_ok, accept;
    logic [QW-1:0]         dvd_abs;
    logic [DATA_WIDTH-1:0] dvs_abs;
    logic [DATA_WIDTH:0]   rem_shift, rem_diff;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (iter_cnt == CW'(QW - 1));
    assign dvd_abs   = dividend[QW-1] ? -dividend : dividend;
    assign dvs_abs   = divisor[DATA_WIDTH-1] ? -divisor : divisor;

    // Partial remainder keeps one spare bit so a divisor magnitude of 2^(DATA_WIDTH-1) cannot overflow.
    assign rem_shift = {rem_reg[DATA_WIDTH-1:0], q_reg[QW-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_mag};
    assign sub_ok    = (rem_shift >= {1'b0, dvs_mag});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = zero_div ? DONE : DIVIDE;
            DIVIDE:  if (last_iter) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // q_reg starts as the dividend magnitude and shifts quotient bits in from the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg    <= '0;
            rem_reg  <= '0;
            dvs_mag  <= '0;
            dvd_neg  <= 1'b0;
            dvs_neg  <= 1'b0;
            iter_cnt <= '0;
        end else if (accept) begin
            q_reg    <= zero_div ? '1 : dvd_abs;
            rem_reg  <= '0;
            dvs_mag  <= dvs_abs;
            dvd_neg  <= dividend[QW-1];
            dvs_neg  <= divisor[DATA_WIDTH-1];
            iter_cnt <= '0;
        end else if (state == DIVIDE) begin
            q_reg    <= {q_reg[QW-2:0], sub_ok};
            rem_reg  <= sub_ok ? rem_diff : rem_shift;
            iter_cnt <= iter_cnt + 1'b1;
        end else if (state == FIXUP) begin
            if (dvd_neg ^ dvs_neg) q_reg <= -q_reg;
            if (dvd_neg)           rem_reg <= -rem_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (state == DONE) begin
            done      <= 1'b1;
            quotient  <= q_reg;
            remainder <= rem_reg[DATA_WIDTH-1:0];
        end else begin
            done      <= 1'b0;
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic dz_reg;
    assign zero_div = (divisor == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dz_reg      <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept)         dz_reg      <= zero_div;
            if (state == DONE)  div_by_zero <= dz_reg;
        end
    end
`else
    assign zero_div    = 1'b0;
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: doc/signed_seq_divider.md
SIGNED_SEQ_DIVIDER -- requirements
Module: signed_seq_divider

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 4: width of the divisor and remainder; dividend and quotient are 2*DATA_WIDTH bits.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request a division; honoured only in IDLE.
REQ-005 The module SHALL have port dividend, input, 2*DATA_WIDTH bits: signed two's-complement operand.
REQ-006 The module SHALL have port divisor, input, DATA_WIDTH bits: signed two's-complement operand.
REQ-007 The module SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 The module SHALL have port done, output, 1 bit: single-cycle result-valid pulse.
REQ-009 The module SHALL have port quotient, output, 2*DATA_WIDTH bits: signed, registered result.
REQ-010 The module SHALL have port remainder, output, DATA_WIDTH bits: signed, registered result.
REQ-011 The module SHALL have port div_by_zero, output, 1 bit: error flag, valid with done.

Function
REQ-012 The FSM SHALL have states IDLE, DIVIDE, FIXUP, DONE.
REQ-013 Transitions SHALL be IDLE->DIVIDE on start; DIVIDE->FIXUP after 2*DATA_WIDTH iterations; FIXUP->DONE; DONE->IDLE unconditionally.
REQ-014 On start in IDLE, the block SHALL capture the operand magnitudes and signs, clear the partial remainder, and clear the iteration counter.
REQ-015 Input changes after capture SHALL have no effect on the running division.
REQ-016 DIVIDE SHALL perform one restoring shift-subtract step per cycle on unsigned magnitudes, producing one quotient bit MSB-first.
REQ-017 The partial remainder register SHALL be DATA_WIDTH+1 bits so that magnitude 2^(DATA_WIDTH-1) does not overflow.
REQ-018 FIXUP SHALL negate the quotient when the operand signs differ, and SHALL negate the remainder when the dividend is negative.
REQ-019 Division SHALL truncate toward zero; remainder sign SHALL equal dividend sign; |remainder| SHALL be less than |divisor|.
REQ-020 In DONE, the registered quotient and remainder SHALL update and done SHALL be 1 for exactly one cycle.
REQ-021 done SHALL be asserted 2*DATA_WIDTH+2 rising edges after the edge that samples start (10 for DATA_WIDTH=4).
REQ-022 quotient, remainder and div_by_zero SHALL hold their values until the next done.
REQ-023 Quotient overflow (most-negative dividend divided by -1) SHALL wrap: quotient = most-negative value, remainder = 0, no flag.
REQ-024 start while busy=1 (including in DONE) SHALL be ignored; start in IDLE on the cycle after done SHALL be accepted.

Reset
REQ-025 While rst=1, state SHALL be IDLE and busy, done, quotient, remainder, div_by_zero SHALL all be 0, asynchronously.
REQ-026 Reset during any state SHALL abort the operation with no done pulse; the first start after release SHALL be honoured normally.

Configuration
REQ-027 The feature SHALL be controlled by macro DIV_ZERO_CHECK_EN.
REQ-028 With DIV_ZERO_CHECK_EN defined, start with divisor=0 SHALL go IDLE->DONE directly: done on the next edge, quotient = all ones, remainder = 0, div_by_zero = 1.
REQ-029 With DIV_ZERO_CHECK_EN defined, div_by_zero SHALL be 0 for every nonzero divisor.
REQ-030 Without DIV_ZERO_CHECK_EN, div_by_zero SHALL be tied to 0.
REQ-031 Without DIV_ZERO_CHECK_EN, divisor=0 SHALL take the normal 2*DATA_WIDTH+2 path with unspecified quotient and remainder.

Verification (DATA_WIDTH=4)
REQ-032 Scenario: dividend=100, divisor=7 -> done 10 edges after start; quotient=14, remainder=2, div_by_zero=0.
REQ-033 Scenario: dividend=-100, divisor=7 -> quotient=-14, remainder=-2; then dividend=100, divisor=-8 -> quotient=-12, remainder=4.
REQ-034 Scenario: dividend=-128, divisor=-1 -> quotient=-128 (0x80), remainder=0.
REQ-035 Scenario (macro defined): divisor=0 -> done 1 edge after start; quotient=0xFF, remainder=0, div_by_zero=1. Follow with 9/3 -> quotient=3, div_by_zero=0.
REQ-036 Scenario: second start pulse and operand change at cycle 4 of a running 50/5 -> ignored; quotient=10, remainder=0; exactly one done.
REQ-037 Scenario: rst asserted at cycle 5 of a division -> outputs 0 immediately, no done; start 20/-3 after release -> quotient=-6, remainder=2.
